// File: rtl/aha_tlx_train_ctrl.sv
// rtl/aha_tlx_train_ctrl.sv - parametrised TLX link-training lane-array controller
//
// Purpose: one IDLE/RUN/DONE training engine per lane. TX lanes (TX_MASK bit = 1)
// drive the 32-bit training pattern or bypass functional data. RX lanes
// (TX_MASK bit = 0) compare incoming bits against the pattern and count matches.
//
// Optional feature macro: AHA_TLX_ERR_CNT_EN (builds per-lane RX error counters;
// when undefined, LANE_ERR_COUNT is tied to 0).
//
// Ports:
//   CLK, RESETn          clock, asynchronous active-low reset
//   LANE_DIN/LANE_DOUT   per-lane pad data in / out
//   LANE_EN, LANE_IE     per-lane enable level, interrupt enable (also auto-stop)
//   LANE_START/CLEAR     per-lane one-cycle pulses
//   LANE_SEQUENCE        32-bit pattern per lane, lane i at [32i+31:32i]
//   LANE_LENGTH          training length in bits per lane (CNT_W each)
//   LANE_MATCH_COUNT     matched-bit count per lane (0 on TX lanes)
//   LANE_ERR_COUNT       mismatched-bit count per lane (0 on TX lanes)
//   LANE_INT_STATUS      sticky done flag per lane
//   LANE_STATUS          lane is in RUN
//   IRQ                  OR of (LANE_INT_STATUS & LANE_IE)

module aha_tlx_train_ctrl #(
    parameter int                   NUM_LANES = 5,
    parameter logic [NUM_LANES-1:0] TX_MASK   = 5'b00111,
    parameter int                   CNT_W     = 32
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    input  logic [NUM_LANES-1:0]       LANE_DIN,
    output logic [NUM_LANES-1:0]       LANE_DOUT,
    input  logic [NUM_LANES-1:0]       LANE_EN,
    input  logic [NUM_LANES-1:0]       LANE_IE,
    input  logic [NUM_LANES-1:0]       LANE_START,
    input  logic [NUM_LANES-1:0]       LANE_CLEAR,
    input  logic [32*NUM_LANES-1:0]    LANE_SEQUENCE,
    input  logic [CNT_W*NUM_LANES-1:0] LANE_LENGTH,
    output logic [CNT_W*NUM_LANES-1:0] LANE_MATCH_COUNT,
    output logic [CNT_W*NUM_LANES-1:0] LANE_ERR_COUNT,
    output logic [NUM_LANES-1:0]       LANE_INT_STATUS,
    output logic [NUM_LANES-1:0]       LANE_STATUS,
    output logic                       IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam bit IS_TX = TX_MASK[i];

        state_t           state_q;
        logic [4:0]       idx_q;
        logic [CNT_W-1:0] bit_cnt_q;
        logic [CNT_W-1:0] match_q;
        logic [CNT_W-1:0] match_d;
        logic [CNT_W-1:0] bit_cnt_d;
        logic [31:0]      seq;
        logic [CNT_W-1:0] len;
        logic             en;
        logic             start;
        logic             auto_stop;
        logic             cur_bit;
        logic             hit;
        logic             is_last;

        assign seq       = LANE_SEQUENCE[32*i +: 32];
        assign len       = LANE_LENGTH[CNT_W*i +: CNT_W];
        assign en        = LANE_EN[i];
        assign start     = LANE_START[i] & en;
        assign auto_stop = LANE_IE[i] & en;
        assign cur_bit   = seq[idx_q];
        assign hit       = (LANE_DIN[i] == cur_bit);
        // LENGTH = 0 in RUN makes len-1 all-ones, which the saturated counter
        // eventually reaches; harmless since zero length normally skips RUN.
        assign is_last   = (bit_cnt_q == (len - CNT_ONE));

        // Saturating increments: counters stick at all-ones in long runs.
        assign match_d   = (match_q == CNT_MAX)   ? match_q   : match_q + CNT_ONE;
        assign bit_cnt_d = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + CNT_ONE;

`ifdef AHA_TLX_ERR_CNT_EN
        logic [CNT_W-1:0] err_q;
        logic [CNT_W-1:0] err_d;
        assign err_d = (err_q == CNT_MAX) ? err_q : err_q + CNT_ONE;
        assign LANE_ERR_COUNT[CNT_W*i +: CNT_W] = IS_TX ? '0 : err_q;
`else
        assign LANE_ERR_COUNT[CNT_W*i +: CNT_W] = '0;
`endif

        // Priority: CLEAR > enable loss > START > advance.
        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                state_q   <= ST_IDLE;
                idx_q     <= '0;
                bit_cnt_q <= '0;
                match_q   <= '0;
`ifdef AHA_TLX_ERR_CNT_EN
                err_q     <= '0;
`endif
            end else if (LANE_CLEAR[i]) begin
                state_q <= ST_IDLE;
                match_q <= '0;
`ifdef AHA_TLX_ERR_CNT_EN
                err_q   <= '0;
`endif
            end else if (!en) begin
                // Abort only leaves RUN; a DONE lane keeps its sticky flag.
                if (state_q == ST_RUN) begin
                    state_q <= ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            idx_q     <= '0;
                            bit_cnt_q <= '0;
                            match_q   <= '0;
`ifdef AHA_TLX_ERR_CNT_EN
                            err_q     <= '0;
`endif
                            state_q   <= (auto_stop && (len == '0)) ? ST_DONE : ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        idx_q     <= idx_q + 5'd1;
                        bit_cnt_q <= bit_cnt_d;
                        if (!IS_TX) begin
                            if (hit) begin
                                match_q <= match_d;
                            end
`ifdef AHA_TLX_ERR_CNT_EN
                            else begin
                                err_q <= err_d;
                            end
`endif
                        end
                        if (auto_stop && is_last) begin
                            state_q <= ST_DONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        assign LANE_STATUS[i]     = (state_q == ST_RUN);
        assign LANE_INT_STATUS[i] = (state_q == ST_DONE);
        assign LANE_MATCH_COUNT[CNT_W*i +: CNT_W] = IS_TX ? '0 : match_q;

        // TX: bypass while disabled, pattern bit while training, else quiet.
        assign LANE_DOUT[i] = !IS_TX ? 1'b0 :
                              !en    ? LANE_DIN[i] :
                              (state_q == ST_RUN) ? cur_bit : 1'b0;
    end

    assign IRQ = |(LANE_INT_STATUS & LANE_IE);

endmodule

// File: tb/tb_aha_tlx_train_ctrl.sv
// tb/tb_aha_tlx_train_ctrl.sv - self-checking bench for aha_tlx_train_ctrl

module tb_aha_tlx_train_ctrl;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance: 5 lanes, lanes 0..2 TX, lanes 3..4 RX, 32-bit counters.
    logic [4:0]   din, dout, en, ie, start, clear, st, ist;
    logic [159:0] seq, len, mcnt, ecnt;
    logic         irq;

    // Wide instance: 8 lanes, lanes 4..7 TX, 8-bit counters.
    logic [7:0]   din8, dout8, en8, ie8, start8, clear8, st8, ist8;
    logic [255:0] seq8;
    logic [63:0]  len8, mcnt8, ecnt8;
    logic         irq8;

    // Single-lane TX instance.
    logic [0:0]   din1, dout1, en1, ie1, start1, clear1, st1, ist1;
    logic [31:0]  seq1;
    logic [7:0]   len1, mcnt1, ecnt1;
    logic         irq1;

    aha_tlx_train_ctrl #(.NUM_LANES(5), .TX_MASK(5'b00111), .CNT_W(32)) dut (
        .CLK(clk), .RESETn(rst_n), .LANE_DIN(din), .LANE_DOUT(dout),
        .LANE_EN(en), .LANE_IE(ie), .LANE_START(start), .LANE_CLEAR(clear),
        .LANE_SEQUENCE(seq), .LANE_LENGTH(len), .LANE_MATCH_COUNT(mcnt),
        .LANE_ERR_COUNT(ecnt), .LANE_INT_STATUS(ist), .LANE_STATUS(st), .IRQ(irq)
    );

    aha_tlx_train_ctrl #(.NUM_LANES(8), .TX_MASK(8'hF0), .CNT_W(8)) dut8 (
        .CLK(clk), .RESETn(rst_n), .LANE_DIN(din8), .LANE_DOUT(dout8),
        .LANE_EN(en8), .LANE_IE(ie8), .LANE_START(start8), .LANE_CLEAR(clear8),
        .LANE_SEQUENCE(seq8), .LANE_LENGTH(len8), .LANE_MATCH_COUNT(mcnt8),
        .LANE_ERR_COUNT(ecnt8), .LANE_INT_STATUS(ist8), .LANE_STATUS(st8), .IRQ(irq8)
    );

    aha_tlx_train_ctrl #(.NUM_LANES(1), .TX_MASK(1'b1), .CNT_W(8)) dut1 (
        .CLK(clk), .RESETn(rst_n), .LANE_DIN(din1), .LANE_DOUT(dout1),
        .LANE_EN(en1), .LANE_IE(ie1), .LANE_START(start1), .LANE_CLEAR(clear1),
        .LANE_SEQUENCE(seq1), .LANE_LENGTH(len1), .LANE_MATCH_COUNT(mcnt1),
        .LANE_ERR_COUNT(ecnt1), .LANE_INT_STATUS(ist1), .LANE_STATUS(st1), .IRQ(irq1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input int lane);
        clear[lane] = 1'b1;
        tick();
        clear[lane] = 1'b0;
        check($sformatf("clr%0d_status", lane), st[lane], 1'b0);
        check($sformatf("clr%0d_int", lane), ist[lane], 1'b0);
        check($sformatf("clr%0d_match", lane), mcnt[32*lane +: 32], 0);
    endtask

    // TX run with auto-stop: RUN cycle k drives pattern bit k mod 32.
    task automatic run_tx(input int lane, input logic [31:0] p, input int L);
        do_clear(lane);
        seq[32*lane +: 32] = p;
        len[32*lane +: 32] = 32'(L);
        en[lane] = 1'b1;
        ie[lane] = 1'b1;
        start[lane] = 1'b1;
        tick();
        start[lane] = 1'b0;
        for (int k = 0; k < L; k++) begin
            check($sformatf("tx%0d_status_k%0d", lane, k), st[lane], 1'b1);
            check($sformatf("tx%0d_dout_k%0d", lane, k), dout[lane], p[k % 32]);
            tick();
        end
        check($sformatf("tx%0d_end_status", lane), st[lane], 1'b0);
        check($sformatf("tx%0d_end_int", lane), ist[lane], 1'b1);
        check($sformatf("tx%0d_end_irq", lane), irq, 1'b1);
        check($sformatf("tx%0d_match", lane), mcnt[32*lane +: 32], 0);
    endtask

    // RX run with auto-stop; flip bit k corrupts the k-th received bit.
    task automatic run_rx(input int lane, input logic [31:0] p, input int L,
                          input logic [127:0] flip);
        int exp_err;
        exp_err = 0;
        for (int k = 0; k < L; k++) if (flip[k]) exp_err++;
        do_clear(lane);
        seq[32*lane +: 32] = p;
        len[32*lane +: 32] = 32'(L);
        en[lane] = 1'b1;
        ie[lane] = 1'b1;
        start[lane] = 1'b1;
        tick();
        start[lane] = 1'b0;
        for (int k = 0; k < L; k++) begin
            din[lane] = p[k % 32] ^ flip[k];
            check($sformatf("rx%0d_status_k%0d", lane, k), st[lane], 1'b1);
            tick();
        end
        check($sformatf("rx%0d_end_status", lane), st[lane], 1'b0);
        check($sformatf("rx%0d_end_int", lane), ist[lane], 1'b1);
        check($sformatf("rx%0d_dout", lane), dout[lane], 1'b0);
        check($sformatf("rx%0d_match_L%0d", lane, L), mcnt[32*lane +: 32], 32'(L - exp_err));
`ifdef AHA_TLX_ERR_CNT_EN
        check($sformatf("rx%0d_err", lane), ecnt[32*lane +: 32], 32'(exp_err));
`else
        check($sformatf("rx%0d_err", lane), ecnt[32*lane +: 32], 0);
`endif
    endtask

    initial begin
        logic [31:0]  p;
        logic [127:0] fl;
        int           n;
        int           run_cycles;

        rst_n = 1'b0;
        {din, en, ie, start, clear} = '0;
        seq = '0; len = '0;
        {din8, en8, ie8, start8, clear8} = '0;
        seq8 = '0; len8 = '0;
        {din1, en1, ie1, start1, clear1} = '0;
        seq1 = '0; len1 = '0;

        // Reset state and bypass mapping.
        repeat (2) tick();
        din  = 5'($urandom);
        din8 = 8'($urandom);
        din1 = 1'($urandom);
        #1;
        check("rst_status", st, 5'd0);
        check("rst_int", ist, 5'd0);
        check("rst_irq", irq, 1'b0);
        check("rst_match", mcnt, 160'd0);
        check("rst_err", ecnt, 160'd0);
        check("rst_dout", dout, {2'b00, din[2:0]});
        check("rst_dout8", dout8, din8 & 8'hF0);
        check("rst_dout1", dout1, din1);
        rst_n = 1'b1;
        tick();

        // TX auto-stop on lane 0 with the reference pattern, then a random one on lane 1.
        run_tx(0, 32'hA5A5_0F0F, 40);
        p = $urandom;
        run_tx(1, p, int'($urandom_range(1, 70)));

        // RX with bits 5 and 37 flipped, then a random RX run on lane 4.
        fl = '0;
        fl[5]  = 1'b1;
        fl[37] = 1'b1;
        p = $urandom;
        run_rx(3, p, 64, fl);
        p  = $urandom;
        fl = {$urandom, $urandom, $urandom, $urandom};
        run_rx(4, p, int'($urandom_range(1, 100)), fl);

        // Continuous mode on lane 4: IE = 0, LENGTH = 8, 100 matching cycles.
        do_clear(4);
        p = $urandom;
        seq[32*4 +: 32] = p;
        len[32*4 +: 32] = 32'd8;
        ie[4] = 1'b0;
        en[4] = 1'b1;
        start[4] = 1'b1;
        tick();
        start[4] = 1'b0;
        run_cycles = 0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            din[4] = p[k % 32];
            if (st[4] === 1'b1) run_cycles++;
            if (ist[4] !== 1'b0) n++;
            tick();
        end
        check("cont_status_cycles", 64'(run_cycles), 64'd100);
        check("cont_int_cycles", 64'(n), 64'd0);
        check("cont_status_after", st[4], 1'b1);
        check("cont_match", mcnt[32*4 +: 32], 32'd100);
        // CLEAR and START together: CLEAR wins.
        clear[4] = 1'b1;
        start[4] = 1'b1;
        tick();
        clear[4] = 1'b0;
        start[4] = 1'b0;
        check("collide_status", st[4], 1'b0);
        check("collide_int", ist[4], 1'b0);
        check("collide_match", mcnt[32*4 +: 32], 0);
        tick();
        check("collide_stays_idle", st[4], 1'b0);

        // Abort: EN drops in RUN cycle 10 of RX lane 3.
        do_clear(3);
        p = $urandom;
        seq[32*3 +: 32] = p;
        len[32*3 +: 32] = 32'd50;
        ie[3] = 1'b1;
        en[3] = 1'b1;
        start[3] = 1'b1;
        tick();
        start[3] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            din[3] = p[k];
            tick();
        end
        en[3] = 1'b0;
        din[3] = 1'($urandom);
        tick();
        check("abort_status", st[3], 1'b0);
        check("abort_match", mcnt[32*3 +: 32], 32'd10);
        check("abort_int", ist[3], 1'b0);

        // Bypass on TX lane 2 with EN = 0, DIN toggling every cycle.
        en[2] = 1'b0;
        din[2] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            din[2] = ~din[2];
            #1;
            check($sformatf("bypass_k%0d", k), dout[2], din[2]);
            tick();
        end

        // Zero length with auto-stop on lane 1, then START in DONE is ignored.
        do_clear(1);
        len[32*1 +: 32] = 32'd0;
        en[1] = 1'b1;
        ie[1] = 1'b1;
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        check("zlen_status", st[1], 1'b0);
        check("zlen_int", ist[1], 1'b1);
        check("zlen_irq", irq, 1'b1);
        len[32*1 +: 32] = 32'd5;
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        check("done_start_status", st[1], 1'b0);
        check("done_start_int", ist[1], 1'b1);

        // IRQ masking: lanes 0 and 1 are DONE.
        ie = 5'b11100;
        #1;
        check("irq_masked", irq, 1'b0);
        ie = 5'b00010;
        #1;
        check("irq_lane1", irq, 1'b1);

        // Wide instance: TX lane 6 short run, RX lane 1 saturating continuous run.
        p = $urandom;
        seq8[32*6 +: 32] = p;
        len8[8*6 +: 8] = 8'd5;
        en8[6] = 1'b1;
        ie8[6] = 1'b1;
        start8[6] = 1'b1;
        tick();
        start8[6] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("w8_tx6_dout_k%0d", k), dout8[6], p[k]);
            check($sformatf("w8_rx_dout_k%0d", k), dout8[3:0], 4'd0);
            tick();
        end
        check("w8_tx6_int", ist8, 8'h40);
        check("w8_irq", irq8, 1'b1);
        p = $urandom;
        seq8[32*1 +: 32] = p;
        len8[8*1 +: 8] = 8'd8;
        en8[1] = 1'b1;
        ie8[1] = 1'b0;
        start8[1] = 1'b1;
        tick();
        start8[1] = 1'b0;
        for (int k = 0; k < 300; k++) begin
            din8[1] = p[k % 32];
            tick();
        end
        check("w8_sat_match", mcnt8[8*1 +: 8], 8'd255);
        check("w8_sat_status", st8, 8'h02);
        check("w8_other_match", mcnt8[8*2 +: 8], 8'd0);
        din8[5] = ~din8[5];
        #1;
        check("w8_bypass5", dout8[5], din8[5]);

        // Single-lane instance: short TX run.
        p = $urandom;
        seq1 = p;
        len1 = 8'd3;
        en1 = 1'b1;
        ie1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("w1_dout_k%0d", k), dout1, p[k]);
            tick();
        end
        check("w1_int", ist1, 1'b1);
        check("w1_irq", irq1, 1'b1);

        // Asynchronous reset mid-RUN on lane 4.
        p = $urandom;
        seq[32*4 +: 32] = p;
        en[4] = 1'b1;
        ie = 5'b11111;
        start[4] = 1'b1;
        tick();
        start[4] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            din[4] = p[k];
            tick();
        end
        check("pre_rst_match", mcnt[32*4 +: 32], 32'd5);
        check("pre_rst_irq", irq, 1'b1);
        #2;
        en = '0;
        rst_n = 1'b0;
        #1;
        check("arst_status", st, 5'd0);
        check("arst_int", ist, 5'd0);
        check("arst_irq", irq, 1'b0);
        check("arst_match", mcnt, 160'd0);
        check("arst_dout", dout, {2'b00, din[2:0]});
        check("arst_int8", ist8, 8'd0);
        check("arst_match8", mcnt8, 64'd0);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
